// File: rtl/pulse_generator.sv
//==============================================================================
// pulse_generator: drives a control line with a programmed train of pulses.
// Revision: 1.0
//==============================================================================
`default_nettype none

module pulse_generator #(
  parameter int   WIDTH_MAX       = 100,
  parameter int   PULSE_NUM_WIDTH = 8,
  parameter logic IDLE_LEVEL      = 1'b0,
  localparam int  COUNTER_WIDTH   = $clog2(WIDTH_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [COUNTER_WIDTH-1:0]   high_cycles,
  input  logic [COUNTER_WIDTH-1:0]   low_cycles,
  input  logic [PULSE_NUM_WIDTH-1:0] pulse_num,
  output logic                       pulse_out,
  output logic                       busy,
  output logic                       done,
  output logic [PULSE_NUM_WIDTH-1:0] pulse_index
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] c_cnt_one = COUNTER_WIDTH'(1);

  logic [1:0]                 r_state, w_state_nx;
  logic [COUNTER_WIDTH-1:0]   r_cnt, w_cnt_nx;
  logic [COUNTER_WIDTH-1:0]   r_hi, w_hi_nx;
  logic [COUNTER_WIDTH-1:0]   r_lo, w_lo_nx;
  logic [PULSE_NUM_WIDTH-1:0] r_num, w_num_nx;
  logic [PULSE_NUM_WIDTH-1:0] r_idx, w_idx_nx;
  logic                       r_pend, w_pend_nx;
  logic                       w_finish;
  logic                       w_pulse_nx, w_busy_nx, w_done_nx;

  // All outputs are registered so the line toggles glitch-free on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_pend    <= 1'b0;
      pulse_out <= IDLE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_num     <= w_num_nx;
      r_idx     <= w_idx_nx;
      r_pend    <= w_pend_nx;
      pulse_out <= w_pulse_nx;
      busy      <= w_busy_nx;
      done      <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_num_nx   = r_num;
    w_idx_nx   = r_idx;
    w_pend_nx  = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_hi_nx  = high_cycles;
          w_lo_nx  = low_cycles;
          w_num_nx = pulse_num;
          w_idx_nx = '0;
          // An empty train completes without ever going busy; done follows a cycle later.
          if (pulse_num == '0 || high_cycles == '0) begin
            w_pend_nx = 1'b1;
          end else begin
            w_state_nx = S_ACTIVE;
            w_cnt_nx   = c_cnt_one;
          end
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == r_hi) begin
          w_idx_nx = r_idx + 1'b1;
          w_cnt_nx = c_cnt_one;
          if (w_idx_nx == r_num) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_finish   = 1'b1;
          end else if (r_lo == '0) begin
            w_state_nx = S_ACTIVE;
          end else begin
            w_state_nx = S_GAP;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == r_lo) begin
          w_state_nx = S_ACTIVE;
          w_cnt_nx   = c_cnt_one;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    w_pulse_nx = (w_state_nx == S_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
    w_busy_nx  = (w_state_nx != S_IDLE);
    w_done_nx  = w_finish | r_pend;
  end

  assign pulse_index = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_pulse_generator.sv
//==============================================================================
// tb_pulse_generator: directed checks of pulse_generator for both idle levels.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_pulse_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] high_cycles = '0;
  logic [6:0] low_cycles = '0;
  logic [7:0] pulse_num = '0;

  logic       p0, busy0, done0;
  logic [7:0] idx0;
  logic       p1, busy1, done1;
  logic [7:0] idx1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_generator #(.WIDTH_MAX(100), .PULSE_NUM_WIDTH(8), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .pulse_num(pulse_num),
    .pulse_out(p0), .busy(busy0), .done(done0), .pulse_index(idx0)
  );

  pulse_generator #(.WIDTH_MAX(100), .PULSE_NUM_WIDTH(8), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .pulse_num(pulse_num),
    .pulse_out(p1), .busy(busy1), .done(done1), .pulse_index(idx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_pulse0", p0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_idx0", idx0, 0);
    check("rst_pulse1", p1, 1);
    rst = 1'b0;
    tick();

    // Two pulses, high=3 low=2
    high_cycles = 7'd3; low_cycles = 7'd2; pulse_num = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("trainA_pulse", p0, (i < 3 || i >= 5) ? 1 : 0);
      check("trainA_busy", busy0, 1);
      check("trainA_done", done0, 0);
      tick();
    end
    check("trainA_end_pulse", p0, 0);
    check("trainA_end_busy", busy0, 0);
    check("trainA_end_done", done0, 1);
    check("trainA_end_idx", idx0, 2);
    tick();
    check("trainA_done_once", done0, 0);

    // Degenerate starts: num=0, then high=0
    for (int c = 0; c < 2; c++) begin
      high_cycles = (c == 0) ? 7'd3 : 7'd0;
      pulse_num   = (c == 0) ? 8'd0 : 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("degen_k_busy", busy0, 0);
      check("degen_k_done", done0, 0);
      check("degen_k_pulse", p0, 0);
      tick();
      check("degen_k1_done", done0, 1);
      check("degen_k1_busy", busy0, 0);
      check("degen_k1_pulse", p0, 0);
      tick();
      check("degen_k2_done", done0, 0);
    end

    // Merged pulses, high=2 low=0 num=3
    high_cycles = 7'd2; low_cycles = 7'd0; pulse_num = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("merge_pulse", p0, 1);
      check("merge_done", done0, 0);
      tick();
    end
    check("merge_end_pulse", p0, 0);
    check("merge_end_done", done0, 1);
    check("merge_end_idx", idx0, 3);
    tick();

    // Abort on the 4th active cycle of a 10-cycle pulse
    high_cycles = 7'd10; pulse_num = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_before", p0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_pulse", p0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    tick();
    check("abort_done_later", done0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("reabort_pulse", p0, 1);
      check("reabort_busy", busy0, 1);
      tick();
    end
    check("reabort_end_pulse", p0, 0);
    check("reabort_end_done", done0, 1);
    tick();

    // Start and config change while busy are ignored; start in done cycle accepted
    high_cycles = 7'd5; pulse_num = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign_pulse0", p0, 1);
    tick();
    start = 1'b1; high_cycles = 7'd1;
    for (int i = 1; i < 5; i++) begin
      check("busy_ign_pulse", p0, 1);
      check("busy_ign_done", done0, 0);
      tick();
    end
    check("busy_ign_end_pulse", p0, 0);
    check("busy_ign_end_busy", busy0, 0);
    check("busy_ign_end_done", done0, 1);
    high_cycles = 7'd2;
    tick();
    start = 1'b0;
    check("b2b_pulse", p0, 1);
    check("b2b_busy", busy0, 1);
    check("b2b_idx", idx0, 0);
    tick();
    check("b2b_pulse2", p0, 1);
    tick();
    check("b2b_done", done0, 1);
    check("b2b_end_pulse", p0, 0);
    tick();

    // Asynchronous reset during GAP, both idle levels
    high_cycles = 7'd3; low_cycles = 7'd4; pulse_num = 8'd2;
    start = 1'b1; start1 = 1'b1;
    tick();
    start = 1'b0; start1 = 1'b0;
    tick(); tick(); tick();
    check("gap_pulse0", p0, 0);
    check("gap_busy0", busy0, 1);
    check("gap_pulse1", p1, 1);
    check("gap_busy1", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pulse0", p0, 0);
    check("arst_busy0", busy0, 0);
    check("arst_done0", done0, 0);
    check("arst_idx0", idx0, 0);
    check("arst_pulse1", p1, 1);
    check("arst_busy1", busy1, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_busy0", busy0, 0);
    check("post_rst_pulse0", p0, 0);
    check("post_rst_pulse1", p1, 1);
    check("post_rst_busy1", busy1, 0);

    // IDLE_LEVEL=1, single pulse of WIDTH_MAX cycles
    high_cycles = 7'd100; low_cycles = 7'd0; pulse_num = 8'd1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("max_pulse1", p1, 0);
      check("max_busy1", busy1, 1);
      tick();
    end
    check("max_end_pulse1", p1, 1);
    check("max_end_busy1", busy1, 0);
    check("max_end_done1", done1, 1);
    check("max_end_idx1", idx1, 1);
    check("max_dut0_idle", busy0, 0);
    tick();
    check("max_done_once1", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_generator.md
# pulse_generator

Programmable pulse-train generator driving a single control line, such as a module mode/trigger pin, for an exact number of clock cycles. It is the driving-side counterpart to the team's level-duration timeout counter: that block measures how long a line sits at a level, and this block produces a level of a precisely programmed length. Configuration is latched on a one-cycle start request. Status is reported through busy and a one-cycle done strobe, so an upstream controller FSM can sequence pin operations.

## Interface
- WIDTH_MAX, 100: largest legal value of high_cycles/low_cycles.
- COUNTER_WIDTH, $clog2(WIDTH_MAX+1): width of the cycle counters and the config inputs (localparam).
- PULSE_NUM_WIDTH, 8: width of pulse_num.
- IDLE_LEVEL, 0: level of pulse_out when not pulsing. The active level is ~IDLE_LEVEL.

Ports:
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- abort  in  1  terminates any operation. Has priority over start.
- high_cycles  in  COUNTER_WIDTH  active-level length per pulse, in cycles.
- low_cycles  in  COUNTER_WIDTH  idle-level gap between pulses, in cycles.
- pulse_num  in  PULSE_NUM_WIDTH  number of pulses in the train.
- pulse_out  out  1  registered line output.
- busy  out  1  high while a train is in progress.
- done  out  1  one-cycle strobe at normal completion.
- pulse_index  out  PULSE_NUM_WIDTH  debug output: pulses completed so far in the current train.

## Operation
- Reset values: pulse_out=IDLE_LEVEL, busy=0, done=0, pulse_index=0, counters=0, state=IDLE. Reset asserted mid-train forces these values immediately, without waiting for a clock edge.
- All inputs are synchronous to clk. There is no input synchronizer.
- States: IDLE, ACTIVE, GAP.
- IDLE behaviour:
  - On start=1 and abort=0, high_cycles, low_cycles and pulse_num are latched.
  - If pulse_num=0 or high_cycles=0: the block stays in IDLE, asserts done for one cycle, and never asserts busy.
  - Otherwise it enters ACTIVE.
- ACTIVE behaviour:
  - pulse_out=~IDLE_LEVEL and the counter counts 1..high_cycles.
  - After the high_cycles-th cycle, pulse_index increments.
  - If this was the last pulse, the block goes to IDLE and asserts done.
  - Otherwise, if low_cycles=0, it re-enters ACTIVE and pulse_out stays active, so consecutive pulses merge.
  - Otherwise it enters GAP.
- GAP behaviour: pulse_out=IDLE_LEVEL for exactly low_cycles cycles, then ACTIVE.
- abort=1 in ACTIVE or GAP: at the next edge the block enters IDLE with pulse_out=IDLE_LEVEL and busy=0, and done is not asserted.
- abort=1 together with start in IDLE: start is ignored.
- Ignored inputs:
  - start while busy=1 is ignored.
  - Changes to the config inputs while busy have no effect on the running train.
- Config values above WIDTH_MAX are not supported. Counter arithmetic is unsigned, with no wrap inside a legal value.
- pulse_index is cleared to 0 on each accepted start.

## Timing
- If start is sampled at edge k, then pulse_out and busy go active at edge k, which is the first output cycle.
- A single pulse:
  - pulse_out stays active for edges k..k+high_cycles-1.
  - At edge k+high_cycles, pulse_out returns to idle, busy=0 and done=1, all for the same cycle.
- Full train: busy stays high for exactly pulse_num·high_cycles + (pulse_num-1)·low_cycles cycles.
- done is high for exactly one cycle.
- A new start is accepted in the same cycle done is high, because state is already IDLE. Back-to-back trains can therefore be separated by a single idle cycle.
- Degenerate start (pulse_num=0 or high_cycles=0): done=1 at edge k+1 only.
- Abort sampled at edge j: pulse_out=IDLE_LEVEL and busy=0 from edge j+1.

## Test plan
- high=3, low=2, num=2, IDLE_LEVEL=0, start at edge 10:
  - required: pulse_out=1 on edges 10-12, 0 on 13-14, 1 on 15-17;
  - busy high on edges 10-17;
  - done=1 only on edge 18, with pulse_index=2.
- num=0 (and separately high=0), start at edge 5: pulse_out never toggles, busy stays 0, done=1 on edge 6 only.
- high=2, low=0, num=3: pulse_out=1 for 6 contiguous cycles, then done for one cycle.
- high=10, num=1, abort on the 4th active cycle: pulse_out=0 and busy=0 on the next edge, and done is never asserted. Then start again: a full 10-cycle pulse is produced.
- While busy with high=5:
  - assert start again and change high_cycles to 1: the running pulse still lasts 5 cycles and no second train starts;
  - assert start in the done cycle: the new train begins the next edge.
- Async reset during GAP, asserted between clock edges: pulse_out=IDLE_LEVEL, busy=0, done=0 immediately. After release the block stays in IDLE until a new start. Repeat with IDLE_LEVEL=1 and high=WIDTH_MAX to check the active level is 0 and the counter reaches the boundary without wrapping.
